// File: rtl/exu_muldiv.sv
// Iterative RV64M multiply/divide unit: a single radix-2 shift-add / restoring
// shift-subtract datapath serves all M-extension ops and their W forms.
module exu_muldiv #(
  parameter int CPU_WIDTH = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [2:0]           i_func3,
  input  logic                 i_word,
  input  logic [CPU_WIDTH-1:0] i_src1,
  input  logic [CPU_WIDTH-1:0] i_src2,
  input  logic                 i_flush,
  output logic                 o_stall,
  output logic                 o_valid,
  output logic [CPU_WIDTH-1:0] o_result
);
  localparam int XL = CPU_WIDTH;
  localparam int HL = CPU_WIDTH / 2;
  localparam int CW = $clog2(CPU_WIDTH);
  localparam logic [XL-1:0] W_MIN = {{(HL+1){1'b1}}, {(HL-1){1'b0}}};
  localparam logic [XL-1:0] X_MIN = {1'b1, {(XL-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_op;
  logic          r_word, r_negq, r_negr, r_valid;
  logic [XL-1:0] r_hi, r_lo, r_dsr, r_result;

  function automatic logic [XL-1:0] sext_h(input logic [HL-1:0] v);
    return {{HL{v[HL-1]}}, v};
  endfunction

  // Operand decode: func3 001..011 have no W form, so i_word is dropped there.
  logic          w_word, w_s1, w_s2, w_na, w_nb, w_div0, w_ovf;
  logic [XL-1:0] w_a, w_b, w_abs_a, w_abs_b, w_dvd, w_spec;
  assign w_word  = i_word & (i_func3[2] | (i_func3[1:0] == 2'b00));
  assign w_s1    = i_func3[2] ? ~i_func3[0] : (i_func3[1:0] != 2'b11);
  assign w_s2    = i_func3[2] ? ~i_func3[0] : ~i_func3[1];
  assign w_a     = !w_word ? i_src1 : w_s1 ? sext_h(i_src1[HL-1:0]) : {{HL{1'b0}}, i_src1[HL-1:0]};
  assign w_b     = !w_word ? i_src2 : w_s2 ? sext_h(i_src2[HL-1:0]) : {{HL{1'b0}}, i_src2[HL-1:0]};
  assign w_na    = w_s1 & w_a[XL-1];
  assign w_nb    = w_s2 & w_b[XL-1];
  assign w_abs_a = w_na ? -w_a : w_a;
  assign w_abs_b = w_nb ? -w_b : w_b;
  assign w_div0  = i_func3[2] & (w_b == '0);
  assign w_ovf   = i_func3[2] & ~i_func3[0] & (w_b == '1) & (w_a == (w_word ? W_MIN : X_MIN));
  assign w_dvd   = w_word ? sext_h(i_src1[HL-1:0]) : i_src1;
  assign w_spec  = i_func3[1] ? (w_div0 ? w_dvd : '0) : (w_div0 ? '1 : w_dvd);

  // One iteration: multiply adds then shifts {hi,lo} right; divide shifts left and trial-subtracts.
  logic [XL:0]   w_msum, w_rsh;
  logic          w_ge;
  logic [XL-1:0] w_madd, w_diff, w_nhi, w_nlo;
  assign w_madd = r_lo[0] ? r_dsr : '0;
  assign w_msum = {1'b0, r_hi} + {1'b0, w_madd};
  assign w_rsh  = {r_hi, r_lo[XL-1]};
  assign w_ge   = w_rsh >= {1'b0, r_dsr};
  assign w_diff = w_rsh[XL-1:0] - r_dsr;
  assign w_nhi  = !r_op[2] ? w_msum[XL:1] : (w_ge ? w_diff : w_rsh[XL-1:0]);
  assign w_nlo  = !r_op[2] ? {w_msum[0], r_lo[XL-1:1]} : {r_lo[XL-2:0], w_ge};

  // After HL multiply steps the product sits HL bits higher in {hi,lo}.
  logic [2*XL-1:0] w_prod, w_prod_s;
  logic [XL-1:0]   w_quo_s, w_rem_s, w_raw, w_fin;
  assign w_prod   = r_word ? {{XL{1'b0}}, w_nhi[HL-1:0], w_nlo[XL-1:HL]} : {w_nhi, w_nlo};
  assign w_prod_s = r_negq ? -w_prod : w_prod;
  assign w_quo_s  = r_negq ? -w_nlo : w_nlo;
  assign w_rem_s  = r_negr ? -w_nhi : w_nhi;
  assign w_raw    = !r_op[2] ? ((r_op[1:0] == 2'b00) ? w_prod_s[XL-1:0] : w_prod_s[2*XL-1:XL])
                             : (r_op[1] ? w_rem_s : w_quo_s);
  assign w_fin    = r_word ? sext_h(w_raw[HL-1:0]) : w_raw;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_word   <= 1'b0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
      r_valid  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dsr    <= '0;
      r_result <= '0;
    end else begin
      r_valid <= 1'b0;
      if (i_flush) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (i_valid) begin
            r_op   <= i_func3;
            r_word <= w_word;
            r_negq <= w_na ^ w_nb;
            r_negr <= w_na;
            if (w_div0 | w_ovf) begin
              r_result <= w_spec;
              r_valid  <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_hi    <= '0;
              // Dividend is left-aligned so the shift-out bit is always lo[MSB].
              r_lo    <= (i_func3[2] & w_word) ? (w_abs_a << HL) : w_abs_a;
              r_dsr   <= w_abs_b;
              r_cnt   <= w_word ? CW'(HL - 1) : CW'(XL - 1);
              r_state <= S_CALC;
            end
          end
          S_CALC: begin
            r_hi  <= w_nhi;
            r_lo  <= w_nlo;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == '0) begin
              r_result <= w_fin;
              r_valid  <= 1'b1;
              r_state  <= S_DONE;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_stall  = ~i_flush & (((r_state == S_IDLE) & i_valid) | (r_state == S_CALC));
  assign o_valid  = r_valid;
  assign o_result = r_result;
endmodule

// File: tb/tb_exu_muldiv.sv
// Bench for exu_muldiv: a plain-arithmetic RV64M model predicts result, latency
// and stall window; one negedge process compares every cycle.
module tb_exu_muldiv;
  logic        clk = 1'b0;
  logic        i_rst, i_valid, i_word, i_flush;
  logic [2:0]  i_func3;
  logic [63:0] i_src1, i_src2;
  logic        o_stall, o_valid;
  logic [63:0] o_result;

  exu_muldiv #(.CPU_WIDTH(64)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_func3(i_func3), .i_word(i_word),
    .i_src1(i_src1), .i_src2(i_src2), .i_flush(i_flush),
    .o_stall(o_stall), .o_valid(o_valid), .o_result(o_result)
  );

  always #5 clk = ~clk;

  localparam int     BIG  = 32'h7fff_ffff;
  localparam longint LMIN = 64'sh8000_0000_0000_0000;
  localparam int     IMIN = 32'sh8000_0000;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_bad = 0;
  bit chk_en = 1'b0;

  // Active operation as seen by the model
  bit          act_on = 1'b0, act_cancel = 1'b0;
  int          act_start = 0, act_lat = 0, act_cut = BIG, act_rst = -1;
  logic [63:0] act_res = '0;
  logic [63:0] exp_res = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ref_res(input logic [2:0] f, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] pa, pb, p;
    longint sa, sb; longint unsigned ua, ub;
    int sa32, sb32; int unsigned ua32, ub32;
    logic [63:0] r; logic [31:0] q;
    logic is_w;
    is_w = w & (f[2] | (f[1:0] == 2'b00));
    r = '0; q = '0;
    if (!f[2]) begin
      pa = (f[1:0] == 2'b11) ? $signed({64'd0, a}) : $signed({{64{a[63]}}, a});
      pb = f[1] ? $signed({64'd0, b}) : $signed({{64{b[63]}}, b});
      p  = pa * pb;
      if (is_w) return sx32(p[31:0]);
      return (f[1:0] == 2'b00) ? p[63:0] : p[127:64];
    end
    if (is_w) begin
      sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
      case (f[1:0])
        2'b00: if (sb32 == 0) q = '1; else if (sa32 == IMIN && sb32 == -1) q = sa32; else q = sa32 / sb32;
        2'b01: if (ub32 == 0) q = '1; else q = ua32 / ub32;
        2'b10: if (sb32 == 0) q = sa32; else if (sa32 == IMIN && sb32 == -1) q = '0; else q = sa32 % sb32;
        default: if (ub32 == 0) q = ua32; else q = ua32 % ub32;
      endcase
      return sx32(q);
    end
    sa = a; sb = b; ua = a; ub = b;
    case (f[1:0])
      2'b00: if (sb == 0) r = '1; else if (sa == LMIN && sb == -1) r = a; else r = sa / sb;
      2'b01: if (ub == 0) r = '1; else r = ua / ub;
      2'b10: if (sb == 0) r = a; else if (sa == LMIN && sb == -1) r = '0; else r = sa % sb;
      default: if (ub == 0) r = a; else r = ua % ub;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic is_w, dz, ov;
    is_w = w & (f[2] | (f[1:0] == 2'b00));
    if (f[2]) begin
      dz = is_w ? (b[31:0] == 32'd0) : (b == 64'd0);
      ov = !f[0] && (is_w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                          : (a == 64'h8000_0000_0000_0000 && b == '1));
      if (dz || ov) return 1;
    end
    return is_w ? 33 : 65;
  endfunction

  always @(negedge clk) begin
    bit ev, es;
    if (chk_en) begin
      ev = act_on && !act_cancel && (cyc == act_start + act_lat);
      es = act_on && (cyc >= act_start) && (cyc < act_start + act_lat) && (cyc < act_cut);
      if (act_rst >= 0 && cyc == act_rst + 1) exp_res = '0;
      if (ev) exp_res = act_res;
      chk("o_valid", 64'(o_valid), 64'(ev));
      chk("o_stall", 64'(o_stall), 64'(es));
      chk("o_result", o_result, exp_res);
    end
  end

  task automatic issue(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b);
    i_valid = 1'b1; i_func3 = f; i_word = w; i_src1 = a; i_src2 = b;
    act_start = cyc; act_lat = ref_lat(f, w, a, b); act_res = ref_res(f, w, a, b);
    act_cut = BIG; act_rst = -1; act_cancel = 1'b0; act_on = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] f, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input bit has_lit, input logic [63:0] lit);
    int lat;
    issue(f, w, a, b);
    lat = act_lat;
    repeat (lat - 1) @(posedge clk);
    @(negedge clk);
    if (has_lit) begin
      chk("lit_valid", 64'(o_valid), 64'd1);
      chk("lit_result", o_result, lit);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_word = 1'b0; i_flush = 1'b0;
    i_func3 = '0; i_src1 = '0; i_src2 = '0;
    repeat (3) @(posedge clk); #1;
    i_rst = 1'b0; chk_en = 1'b1;
    @(posedge clk); #1;

    run_op(3'b000, 0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 1, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(3'b011, 0, '1, '1, 1, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(3'b010, 0, '1, 64'd2, 1, '1);
    run_op(3'b100, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'b110, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, '1);
    run_op(3'b101, 0, 64'd77, 64'd0, 1, '1);
    run_op(3'b110, 0, 64'h1234, 64'd0, 1, 64'h1234);
    run_op(3'b100, 0, 64'h8000_0000_0000_0000, '1, 1, 64'h8000_0000_0000_0000);
    run_op(3'b110, 0, 64'h8000_0000_0000_0000, '1, 1, 64'd0);
    run_op(3'b100, 1, 64'h0000_0000_8000_0000, '1, 1, 64'hFFFF_FFFF_8000_0000);
    run_op(3'b111, 1, 64'hFFFF_FFFF_0000_000B, 64'd3, 1, 64'd2);
    run_op(3'b000, 1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(3'b100, 1, 64'h1234_5678_FFFF_FFEC, 64'd3, 1, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(3'b110, 1, 64'h1234_5678_FFFF_FFEC, 64'd3, 1, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(3'b101, 1, 64'h0000_0000_FFFF_FFFF, 64'd1, 1, '1);
    run_op(3'b001, 1, '1, '1, 1, 64'd0);
    run_op(3'b101, 0, '1, 64'h10, 1, 64'h0FFF_FFFF_FFFF_FFFF);
    run_op(3'b111, 0, '1, 64'h10, 1, 64'hF);
    run_op(3'b111, 1, 64'd5, 64'hABCD_0000_0000_0000, 1, 64'd5);

    // Flush mid-divide, then a multiply accepted on the very next cycle.
    issue(3'b100, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);
    repeat (9) @(posedge clk); #1;
    i_flush = 1'b1; act_cut = cyc; act_cancel = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    run_op(3'b000, 0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 1, 64'hFFFF_FFFF_FFFF_FFF1);

    // Flush together with i_valid in IDLE: nothing accepted.
    i_valid = 1'b1; i_flush = 1'b1; i_func3 = 3'b000; i_src1 = 64'd9; i_src2 = 64'd9;
    @(negedge clk);
    chk("flush_idle_stall", 64'(o_stall), 64'd0);
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Reset in the middle of a multiply.
    issue(3'b000, 0, 64'd12345, 64'd678);
    repeat (19) @(posedge clk); #1;
    i_rst = 1'b1; act_cut = cyc + 1; act_cancel = 1'b1; act_rst = cyc;
    @(posedge clk); #1;
    i_rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_stall", 64'(o_stall), 64'd0);
    chk("rst_result", o_result, 64'd0);
    @(posedge clk); #1;
    run_op(3'b001, 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 64'h4000_0000_0000_0000);

    for (int k = 0; k < 8; k++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = (k % 3 == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom};
      run_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ra, rb, 0, '0);
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
